// File: rtl/npc_ras.sv
// -----------------------------------------------------------------------------
// npc_ras
//   Next-PC selection for the fetch stage, together with a small circular
//   return-address stack (RAS). The RAS predicts jr $31 targets and counts
//   return mispredicts.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   reset    in   asynchronous reset, active low
//   stall    in   F/D stall (F holds PC, D does not advance)
//   req      in   exception / interrupt request
//   eret     in   D-stage eret
//   epc      in   eret return address
//   d_pc     in   PC of the D-stage instruction
//   imm26    in   D-stage instruction index / offset field
//   rs       in   forwarded rs value
//   br       in   branch kind: 0 pc+4, 1 j/jal, 2 jr/jalr, 3 conditional branch
//   b_jump   in   conditional branch taken
//   call     in   D instruction is jal/jalr
//   ret      in   D instruction is jr $31
//   pc       out  registered F-stage PC
//   npc      out  combinational next PC
//   ras_top  out  predicted return address (0 when the stack is empty)
//   ras_cnt  out  number of valid RAS entries
//   mispred  out  saturating count of return mispredicts
// -----------------------------------------------------------------------------
module npc_ras #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
   parameter int          RAS_DEPTH = 4,
   parameter int          CNT_W     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         req,
   input  logic                         eret,
   input  logic [31:0]                  epc,
   input  logic [31:0]                  d_pc,
   input  logic [25:0]                  imm26,
   input  logic [31:0]                  rs,
   input  logic [2:0]                   br,
   input  logic                         b_jump,
   input  logic                         call,
   input  logic                         ret,
   output logic [31:0]                  pc,
   output logic [31:0]                  npc,
   output logic [31:0]                  ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
   output logic [CNT_W-1:0]             mispred
);

   localparam int              PTR_W   = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

   logic [31:0]       pc_q, pc_d;
   logic [31:0]       pc_plus4;
   logic [31:0]       br_target;
   logic              advance;

   logic [31:0]       ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [PTR_W-1:0]  top_idx;
   logic [PTR_W-1:0]  wr_idx;
   logic              push_en;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]  mis_q, mis_d;

   // ---------------------------------------------------------------------------
   // Next-PC selection
   // ---------------------------------------------------------------------------
   assign pc_plus4  = pc_q + 32'd4;
   // Conditional branch: D-stage PC + 4 + sign-extended 16-bit word offset.
   assign br_target = d_pc + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};

   always_comb begin
      npc = pc_plus4;
      if (req) begin
         npc = EXC_VEC;
      end else if (eret) begin
         npc = epc;
      end else begin
         unique case (br)
            3'd1:    npc = {d_pc[31:28], imm26, 2'b00};
            3'd2:    npc = rs;
            3'd3:    npc = b_jump ? br_target : pc_plus4;
            default: npc = pc_plus4;
         endcase
      end
   end

   // Redirects (req/eret) override a stall; otherwise a stall freezes F.
   assign pc_d    = (req || eret || !stall) ? npc : pc_q;
   // Only an advancing D instruction may touch the RAS or the counter.
   assign advance = !stall && !req && !eret;

   // ---------------------------------------------------------------------------
   // Return-address stack
   //   sp_q points at the next free slot; the top entry lives at sp_q-1.
   //   When full, sp_q points at the oldest entry, so a push overwrites it.
   // ---------------------------------------------------------------------------
   assign top_idx = sp_q - PTR_W'(1);
   assign ras_top = (cnt_q == '0) ? 32'h0 : ras_q[top_idx];

   always_comb begin
      sp_d    = sp_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      push_en = 1'b0;
      wr_idx  = sp_q;
      if (advance) begin
         // Pop is evaluated before push so call+ret replaces the top entry.
         if (ret) begin
            // An empty stack predicts 0, so it mispredicts unless rs is 0.
            if ((ras_top != rs) && (mis_q != '1)) begin
               mis_d = mis_q + CNT_W'(1);
            end
            if (cnt_q != '0) begin
               sp_d  = top_idx;
               cnt_d = cnt_q - (PTR_W+1)'(1);
            end
         end
         if (call) begin
            push_en = 1'b1;
            wr_idx  = sp_d;
            sp_d    = sp_d + PTR_W'(1);
            if (cnt_d != DEPTH_C) begin
               cnt_d = cnt_d + (PTR_W+1)'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         sp_q  <= '0;
         cnt_q <= '0;
         mis_q <= '0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         mis_q <= mis_d;
      end
   end

   // Entry storage carries no reset; ras_top masks it while the stack is empty.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_q[wr_idx] <= d_pc + 32'd8;
      end
   end

   assign pc      = pc_q;
   assign ras_cnt = cnt_q;
   assign mispred = mis_q;

endmodule

// File: tb/tb_npc_ras.sv
module tb_npc_ras;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, req, eret, b_jump, call, ret;
   logic [31:0] epc, d_pc, rs;
   logic [25:0] imm26;
   logic [2:0]  br;

   logic [31:0] pc, npc, ras_top;
   logic [2:0]  ras_cnt;
   logic [7:0]  mispred;

   logic [31:0] pc2, npc2, ras_top2;
   logic [2:0]  ras_cnt2;
   logic [1:0]  mispred2;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q [$];
   logic [31:0] cur_pc;

   always #5 clk = ~clk;

   npc_ras dut (
      .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
      .epc(epc), .d_pc(d_pc), .imm26(imm26), .rs(rs), .br(br),
      .b_jump(b_jump), .call(call), .ret(ret),
      .pc(pc), .npc(npc), .ras_top(ras_top), .ras_cnt(ras_cnt), .mispred(mispred)
   );

   npc_ras #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
      .epc(epc), .d_pc(d_pc), .imm26(imm26), .rs(rs), .br(br),
      .b_jump(b_jump), .call(call), .ret(ret),
      .pc(pc2), .npc(npc2), .ras_top(ras_top2), .ras_cnt(ras_cnt2), .mispred(mispred2)
   );

   typedef struct {
      logic        req;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] d_pc;
      logic [25:0] imm26;
      logic [31:0] rs;
      logic [2:0]  br;
      logic        b_jump;
      logic [31:0] exp_npc;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(input logic r, input logic e, input logic [31:0] ep,
                               input logic [31:0] dp, input logic [25:0] im,
                               input logic [31:0] rv, input logic [2:0] b,
                               input logic bj, input logic [31:0] ex);
      vec_t v;
      v.req = r; v.eret = e; v.epc = ep; v.d_pc = dp; v.imm26 = im;
      v.rs = rv; v.br = b; v.b_jump = bj; v.exp_npc = ex;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Queue the expected PC, advance one edge, then compare what the DUT loaded.
   task automatic tick(input logic [31:0] exp_pc);
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk("pc", pc, exp_q.pop_front());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1'b0, 1'b0, 32'h0, 32'h0,         26'h0,       32'h0,         3'd0, 1'b0, 32'h0000_300C);
      vecs[1]  = mk(1'b0, 1'b0, 32'h0, 32'h0000_3010, 26'h0000C10, 32'h0,         3'd1, 1'b0, 32'h0000_3040);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0000_3010, 26'h000FFFF, 32'h0,         3'd3, 1'b1, 32'h0000_3010);
      vecs[3]  = mk(1'b0, 1'b0, 32'h0, 32'h0000_3010, 26'h000FFFF, 32'h0,         3'd3, 1'b0, 32'h0000_300C);
      vecs[4]  = mk(1'b0, 1'b0, 32'h0, 32'h0,         26'h0,       32'h1234_5678, 3'd2, 1'b0, 32'h1234_5678);
      vecs[5]  = mk(1'b0, 1'b1, 32'h0000_3100, 32'h0, 26'h0000C10, 32'h0,         3'd1, 1'b0, 32'h0000_3100);
      vecs[6]  = mk(1'b1, 1'b1, 32'h0000_3100, 32'h0, 26'h0,       32'h0,         3'd2, 1'b0, 32'h0000_4180);
      vecs[7]  = mk(1'b0, 1'b0, 32'h0, 32'hF000_0000, 26'h3FFFFFF, 32'h0,         3'd1, 1'b0, 32'hFFFF_FFFC);
      vecs[8]  = mk(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 26'h0000001, 32'h0,         3'd3, 1'b1, 32'h0000_0004);
      vecs[9]  = mk(1'b0, 1'b0, 32'h0, 32'h0002_0000, 26'h0008000, 32'h0,         3'd3, 1'b1, 32'h0000_0004);
      vecs[10] = mk(1'b0, 1'b0, 32'h0, 32'h0,         26'h0,       32'h0,         3'd5, 1'b1, 32'h0000_300C);

      reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0; b_jump = 1'b0;
      call = 1'b0; ret = 1'b0; epc = '0; d_pc = '0; rs = '0; imm26 = '0; br = 3'd0;

      // Reset state
      #12;
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_cnt", 32'(ras_cnt), 32'd0);
      chk("rst_mis", 32'(mispred), 32'd0);
      chk("rst_top", ras_top, 32'd0);
      reset = 1'b1;

      // Sequential fetch after release
      tick(32'h0000_3004);
      tick(32'h0000_3008);
      stall = 1'b1;

      // Combinational next-PC table, F held by stall between rows
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         req = vecs[i].req; eret = vecs[i].eret; epc = vecs[i].epc;
         d_pc = vecs[i].d_pc; imm26 = vecs[i].imm26; rs = vecs[i].rs;
         br = vecs[i].br; b_jump = vecs[i].b_jump;
         #1;
         chk($sformatf("npc[%0d]", i), npc, vecs[i].exp_npc);
         req = 1'b0; eret = 1'b0;
      end
      br = 3'd0; b_jump = 1'b0; rs = '0;
      chk("table_hold_pc", pc, 32'h0000_3008);

      // Redirects override stall; RAS untouched while redirecting or stalled
      req = 1'b1; call = 1'b1; d_pc = 32'h0000_3000;
      tick(32'h0000_4180);
      chk("req_cnt", 32'(ras_cnt), 32'd0);
      req = 1'b0; call = 1'b0; eret = 1'b1; epc = 32'h0000_3100; ret = 1'b1; rs = 32'h5;
      tick(32'h0000_3100);
      chk("eret_mis", 32'(mispred), 32'd0);
      eret = 1'b0; ret = 1'b0; call = 1'b1;
      tick(32'h0000_3100);
      chk("stall_cnt", 32'(ras_cnt), 32'd0);
      call = 1'b0; stall = 1'b0;
      cur_pc = 32'h0000_3100;

      // Five calls into a 4-deep stack
      for (int i = 0; i < 5; i++) begin
         call = 1'b1; d_pc = 32'h0000_3000 + 32'(i * 16);
         tick(cur_pc + 32'd4); cur_pc += 32'd4;
         if (i == 0) begin
            chk("push1_top", ras_top, 32'h0000_3008);
            chk("push1_cnt", 32'(ras_cnt), 32'd1);
         end
      end
      call = 1'b0;
      chk("full_cnt", 32'(ras_cnt), 32'd4);
      chk("full_top", ras_top, 32'h0000_3048);

      // Four matching returns
      for (int i = 0; i < 4; i++) begin
         ret = 1'b1; rs = 32'h0000_3048 - 32'(i * 16);
         tick(cur_pc + 32'd4); cur_pc += 32'd4;
         chk($sformatf("ret_mis[%0d]", i), 32'(mispred), 32'd0);
      end
      chk("empty_cnt", 32'(ras_cnt), 32'd0);
      chk("empty_top", ras_top, 32'd0);
      rs = 32'h0000_3008;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("ret_empty_mis", 32'(mispred), 32'd1);
      chk("ret_empty_cnt", 32'(ras_cnt), 32'd0);
      chk("ret_empty_mis2", 32'(mispred2), 32'd1);
      rs = 32'h0;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("ret_empty_rs0", 32'(mispred), 32'd1);

      // Call and return together replace the top entry
      ret = 1'b0; call = 1'b1; d_pc = 32'h0000_3010;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("cr_pre_top", ras_top, 32'h0000_3018);
      ret = 1'b1; rs = 32'h0000_3018; d_pc = 32'h0000_3100;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("cr_mis", 32'(mispred), 32'd1);
      chk("cr_top", ras_top, 32'h0000_3108);
      chk("cr_cnt", 32'(ras_cnt), 32'd1);
      call = 1'b0; rs = 32'h0000_3108;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("cr_pop_cnt", 32'(ras_cnt), 32'd0);
      chk("cr_pop_mis", 32'(mispred), 32'd1);

      // Saturation of a 2-bit counter
      rs = 32'h1;
      for (int i = 0; i < 4; i++) begin
         tick(cur_pc + 32'd4); cur_pc += 32'd4;
         chk($sformatf("sat2[%0d]", i), 32'(mispred2), (i == 0) ? 32'd2 : 32'd3);
      end
      chk("sat8", 32'(mispred), 32'd5);

      // Stalled return leaves the counter alone
      stall = 1'b1; rs = 32'h7;
      tick(cur_pc);
      chk("stall_ret_mis", 32'(mispred), 32'd5);
      stall = 1'b0; ret = 1'b0;

      // Asynchronous reset in the middle of operation
      call = 1'b1; d_pc = 32'h0000_3200;
      tick(cur_pc + 32'd4); cur_pc += 32'd4;
      chk("pre_rst_cnt", 32'(ras_cnt), 32'd1);
      call = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h0000_3000);
      chk("arst_cnt", 32'(ras_cnt), 32'd0);
      chk("arst_top", ras_top, 32'd0);
      chk("arst_mis", 32'(mispred), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick(32'h0000_3004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/npc_ras.md
NPC_RAS -- requirements
Module: npc_ras

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180, exception handler entry address.
REQ-003 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; power of two, minimum 2.
REQ-004 Parameter CNT_W, default 8, width of the return-mispredict counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 stall  in  1  F/D stall; 1 = F holds PC and D instruction does not advance.
REQ-008 req  in  1  exception/interrupt request.
REQ-009 eret  in  1  D-stage eret.
REQ-010 epc  in  32  return address for eret.
REQ-011 d_pc  in  32  PC of the D-stage instruction.
REQ-012 imm26  in  26  D-stage instruction index/offset field.
REQ-013 rs  in  32  forwarded rs value.
REQ-014 br  in  3  branch kind: 0 pc4, 1 addr (j/jal), 2 reg (jr/jalr), 3 branch.
REQ-015 b_jump  in  1  branch condition true.
REQ-016 call  in  1  D instruction is jal/jalr.
REQ-017 ret  in  1  D instruction is jr $31.
REQ-018 pc  out  32  registered F-stage PC.
REQ-019 npc  out  32  combinational next PC.
REQ-020 ras_top  out  32  predicted return address (top of stack, 0 when empty).
REQ-021 ras_cnt  out  log2(RAS_DEPTH)+1  valid entry count.
REQ-022 mispred  out  CNT_W  saturating count of return mispredicts.

Function
REQ-023 npc priority, combinational: req -> EXC_VEC; eret -> epc; br=1 -> {d_pc[31:28], imm26, 2'b00}; br=2 -> rs; br=3 and b_jump -> d_pc+4+sign-extended imm26[15:0]<<2; otherwise pc+4.
REQ-024 All address adds are modulo 2^32; carry out is discarded.
REQ-025 pc update each rising edge: req or eret -> load npc regardless of stall; else stall -> hold; else load npc.
REQ-026 The D instruction "advances" in a cycle when stall=0, req=0 and eret=0; RAS and counter update only on advancing cycles.
REQ-027 call on advancing cycle: push d_pc+8; ras_cnt increments up to RAS_DEPTH.
REQ-028 Push when full: circular overwrite of the oldest entry; ras_cnt stays RAS_DEPTH.
REQ-029 ret on advancing cycle: compare ras_top with rs; on inequality mispred increments, saturating at all-ones; then pop if ras_cnt>0.
REQ-030 ret with empty stack: counted as mispredict (unless rs==0); no pointer change; ras_cnt stays 0.
REQ-031 call and ret in the same advancing cycle: pop evaluation first, then push (top replaced, count unchanged when non-empty).
REQ-032 ras_top reads the current top entry combinationally; 0 when ras_cnt=0.
REQ-033 req, eret and stall leave RAS contents, pointer and counter unchanged.

Reset
REQ-034 While reset=0: pc=RESET_PC, ras_cnt=0, mispred=0, stack pointer=0; entry contents are don't-care but ras_top reads 0.
REQ-035 Reset asserted mid-operation takes effect immediately (asynchronously); the first edge after release loads npc from pc=RESET_PC.

Verification
REQ-036 Release reset, no stall, br=0 -> pc 0x3000, 0x3004, 0x3008 on consecutive edges.
REQ-037 d_pc=0x3010, br=1, imm26=0x0000C10 -> npc=0x0000_3040; with br=3, b_jump=1, imm26[15:0]=0xFFFF -> npc=0x0000_3010.
REQ-038 stall=1 with req=1 -> next pc=0x4180; stall=1, req=0, eret=1, epc=0x3100 -> pc=0x3100; stall=1 alone -> pc holds.
REQ-039 Five calls at d_pc=0x3000,0x3010,0x3020,0x3030,0x3040 (depth 4) -> ras_cnt=4, ras_top=0x3048; four matching rets -> mispred=0, ras_cnt=0; fifth ret with rs=0x3008 -> mispred=1.
REQ-040 CNT_W=2, four mismatching rets -> mispred stays 3.
REQ-041 call and ret together with ras_top=0x3018, rs=0x3018, d_pc=0x3100 -> mispred unchanged, ras_top=0x3108, ras_cnt unchanged.
